// File: rtl/xor_frame_checksum_pkg.sv
// Shared types and helpers for the streaming XOR frame checksum engine.
package xor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Widest word xor_reduce accepts; narrower words are zero-extended, which
  // leaves the reduction unchanged.
  localparam int XOR_MAX_W = 64;

  function automatic logic xor_reduce(input logic [XOR_MAX_W-1:0] v);
    logic r;
    r = 1'b0;
    for (int i = 0; i < XOR_MAX_W; i++) r = r ^ v[i];
    return r;
  endfunction

endpackage

// File: rtl/xor_frame_checksum_if.sv
// Input beat stream and result handshake of the XOR frame checksum engine.
interface xor_frame_checksum_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
);
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             s_last;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_sum;
  logic             m_parity;
  logic [LEN_W-1:0] m_count;
  logic             m_ovf;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_sum, m_parity, m_count, m_ovf
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_sum, m_parity, m_count, m_ovf
  );
endinterface

// File: rtl/xor_frame_checksum_sat_counter.sv
// Saturating beat counter with clear, load-1, increment and sticky overflow.
module xor_sat_counter #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             ld1,
  input  logic             inc,
  output logic [LEN_W-1:0] cnt,
  output logic             ovf,
  output logic [LEN_W-1:0] inc_cnt,
  output logic             inc_ovf
);
  logic at_max;

  // inc_cnt/inc_ovf preview the post-increment value so the last beat of a
  // frame can be reported without waiting for the register update.
  assign at_max  = &cnt;
  assign inc_cnt = at_max ? cnt : cnt + LEN_W'(1);
  assign inc_ovf = ovf | at_max;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (ld1) begin
      cnt <= LEN_W'(1);
      ovf <= 1'b0;
    end else if (inc) begin
      cnt <= inc_cnt;
      ovf <= inc_ovf;
    end
  end
endmodule

// File: rtl/xor_frame_checksum.sv
// Streaming XOR checksum: accumulates a frame of words, reports sum/parity/count.
module xor_frame_checksum
  import xor_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  xor_frame_checksum_if.slave bus
);
  state_t           state, state_nxt;
  logic             accept, ready, busy;
  logic             cnt_clr, cnt_ld1, cnt_inc;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0] sum_q;
  logic             par_q, ovf_q;
  logic [LEN_W-1:0] count_q;
  logic [LEN_W-1:0] cnt, inc_cnt;
  logic             ovf, inc_ovf;

  assign accept  = bus.s_valid && ready;
  assign acc_nxt = (state == IDLE) ? bus.s_data : (acc ^ bus.s_data);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = bus.s_last ? HOLD : ACC;
      ACC:     if (accept && bus.s_last) state_nxt = HOLD;
      HOLD:    if (bus.m_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // s_ready depends on state only, so a held result always costs one gap cycle.
  always_comb begin
    ready   = (state != HOLD);
    busy    = (state == HOLD);
    cnt_clr = accept && bus.s_last;
    cnt_ld1 = accept && !bus.s_last && (state == IDLE);
    cnt_inc = accept && !bus.s_last && (state == ACC);
  end

  xor_sat_counter #(.LEN_W(LEN_W)) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cnt_clr),
    .ld1     (cnt_ld1),
    .inc     (cnt_inc),
    .cnt     (cnt),
    .ovf     (ovf),
    .inc_cnt (inc_cnt),
    .inc_ovf (inc_ovf)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc     <= '0;
      sum_q   <= '0;
      par_q   <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      if (bus.s_last) begin
        sum_q   <= acc_nxt;
        par_q   <= xor_reduce(XOR_MAX_W'(acc_nxt));
        count_q <= (state == IDLE) ? LEN_W'(1) : inc_cnt;
        ovf_q   <= (state == IDLE) ? 1'b0 : inc_ovf;
      end else begin
        acc <= acc_nxt;
      end
    end
  end

  assign bus.s_ready  = ready;
  assign bus.m_valid  = busy;
  assign bus.m_sum    = sum_q;
  assign bus.m_parity = par_q;
  assign bus.m_count  = count_q;
  assign bus.m_ovf    = ovf_q;

  logic unused_ok;
  assign unused_ok = ^{cnt, ovf};
endmodule

// File: tb/tb_xor_frame_checksum.sv
// Directed bench for xor_frame_checksum: default build plus a LEN_W=2 build.
module tb_xor_frame_checksum;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  xor_frame_checksum_if #(.WIDTH(8), .LEN_W(8)) bus ();
  xor_frame_checksum_if #(.WIDTH(8), .LEN_W(2)) bus2 ();

  xor_frame_checksum #(.WIDTH(8), .LEN_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  xor_frame_checksum #(.WIDTH(8), .LEN_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  // Drive one beat, let it cross an edge, sample #1 later.
  task automatic beat(input logic [7:0] d, input logic l);
    bus.s_valid = 1'b1; bus.s_data = d; bus.s_last = l;
    @(posedge clk); #1;
    bus.s_valid = 1'b0; bus.s_last = 1'b0;
  endtask

  task automatic beat2(input logic [7:0] d, input logic l);
    bus2.s_valid = 1'b1; bus2.s_data = d; bus2.s_last = l;
    @(posedge clk); #1;
    bus2.s_valid = 1'b0; bus2.s_last = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.m_valid, bus.m_sum, bus.m_parity, bus.m_count, bus.m_ovf} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%0b sum=%h p=%0b cnt=%0d ovf=%0b want all 0",
               bus.m_valid, bus.m_sum, bus.m_parity, bus.m_count, bus.m_ovf);
    end
    checks++;
    if (bus.s_ready !== 1'b1) begin
      errors++; $display("FAIL reset_s_ready got %0b want 1", bus.s_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    beat(8'h12, 1'b0); beat(8'h34, 1'b0); beat(8'h56, 1'b1);
    checks++;
    if ({bus.m_valid, bus.m_sum, bus.m_parity, bus.m_count, bus.m_ovf} !== {1'b1, 8'h70, 1'b1, 8'd3, 1'b0}) begin
      errors++;
      $display("FAIL basic_result got v=%0b sum=%h p=%0b cnt=%0d ovf=%0b want v=1 sum=70 p=1 cnt=3 ovf=0",
               bus.m_valid, bus.m_sum, bus.m_parity, bus.m_count, bus.m_ovf);
    end
    checks++;
    if (bus.s_ready !== 1'b0) begin
      errors++; $display("FAIL basic_hold_ready got %0b want 0", bus.s_ready);
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.m_valid, bus.s_ready, bus.m_sum} !== {1'b0, 1'b1, 8'h70}) begin
      errors++;
      $display("FAIL basic_idle got v=%0b rdy=%0b sum=%h want v=0 rdy=1 sum=70",
               bus.m_valid, bus.s_ready, bus.m_sum);
    end
  endtask

  task automatic test_single;
    beat(8'hA5, 1'b1);
    checks++;
    if ({bus.m_valid, bus.m_sum, bus.m_parity, bus.m_count, bus.m_ovf} !== {1'b1, 8'hA5, 1'b0, 8'd1, 1'b0}) begin
      errors++;
      $display("FAIL single_result got v=%0b sum=%h p=%0b cnt=%0d ovf=%0b want v=1 sum=a5 p=0 cnt=1 ovf=0",
               bus.m_valid, bus.m_sum, bus.m_parity, bus.m_count, bus.m_ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    bus.m_ready = 1'b0;
    beat(8'h0F, 1'b0); beat(8'hF0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      bus.s_valid = 1'b1; bus.s_data = 8'hAA; bus.s_last = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({bus.m_valid, bus.s_ready, bus.m_sum, bus.m_count} !== {1'b1, 1'b0, 8'hFF, 8'd2}) begin
        errors++;
        $display("FAIL hold_cycle%0d got v=%0b rdy=%0b sum=%h cnt=%0d want v=1 rdy=0 sum=ff cnt=2",
                 i, bus.m_valid, bus.s_ready, bus.m_sum, bus.m_count);
      end
    end
    bus.s_valid = 1'b0; bus.s_last = 1'b0;
    bus.m_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.m_valid !== 1'b0) begin
      errors++; $display("FAIL hold_release got v=%0b want 0", bus.m_valid);
    end
    beat(8'h33, 1'b1);
    checks++;
    if ({bus.m_valid, bus.m_sum, bus.m_count} !== {1'b1, 8'h33, 8'd1}) begin
      errors++;
      $display("FAIL after_hold got v=%0b sum=%h cnt=%0d want v=1 sum=33 cnt=1",
               bus.m_valid, bus.m_sum, bus.m_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_bubble;
    beat(8'h01, 1'b0);
    bus.s_data = 8'hEE; bus.s_last = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.m_valid !== 1'b0) begin
      errors++; $display("FAIL bubble_no_result got v=%0b want 0", bus.m_valid);
    end
    beat(8'h02, 1'b1);
    checks++;
    if ({bus.m_valid, bus.m_sum, bus.m_parity, bus.m_count} !== {1'b1, 8'h03, 1'b0, 8'd2}) begin
      errors++;
      $display("FAIL bubble_result got v=%0b sum=%h p=%0b cnt=%0d want v=1 sum=03 p=0 cnt=2",
               bus.m_valid, bus.m_sum, bus.m_parity, bus.m_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort;
    beat(8'hFF, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if ({bus.m_valid, bus.s_ready} !== 2'b01) begin
      errors++;
      $display("FAIL abort_state got v=%0b rdy=%0b want v=0 rdy=1", bus.m_valid, bus.s_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.m_valid !== 1'b0) begin
      errors++; $display("FAIL abort_no_result got v=%0b want 0", bus.m_valid);
    end
    beat(8'h01, 1'b1);
    checks++;
    if ({bus.m_valid, bus.m_sum, bus.m_parity, bus.m_count, bus.m_ovf} !== {1'b1, 8'h01, 1'b1, 8'd1, 1'b0}) begin
      errors++;
      $display("FAIL abort_fresh got v=%0b sum=%h p=%0b cnt=%0d ovf=%0b want v=1 sum=01 p=1 cnt=1 ovf=0",
               bus.m_valid, bus.m_sum, bus.m_parity, bus.m_count, bus.m_ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturate;
    for (int i = 0; i < 5; i++) beat2(8'h01, (i == 4));
    checks++;
    if ({bus2.m_valid, bus2.m_sum, bus2.m_count, bus2.m_ovf} !== {1'b1, 8'h01, 2'd3, 1'b1}) begin
      errors++;
      $display("FAIL sat_result got v=%0b sum=%h cnt=%0d ovf=%0b want v=1 sum=01 cnt=3 ovf=1",
               bus2.m_valid, bus2.m_sum, bus2.m_count, bus2.m_ovf);
    end
    @(posedge clk); #1;
    beat2(8'h5A, 1'b1);
    checks++;
    if ({bus2.m_valid, bus2.m_sum, bus2.m_count, bus2.m_ovf} !== {1'b1, 8'h5A, 2'd1, 1'b0}) begin
      errors++;
      $display("FAIL sat_clear got v=%0b sum=%h cnt=%0d ovf=%0b want v=1 sum=5a cnt=1 ovf=0",
               bus2.m_valid, bus2.m_sum, bus2.m_count, bus2.m_ovf);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0; bus.m_ready = 1'b1;
    bus2.s_valid = 1'b0; bus2.s_data = '0; bus2.s_last = 1'b0; bus2.m_ready = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_single();
    test_backpressure();
    test_bubble();
    test_reset_abort();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
